// File: rtl/apb_uart_csr_pkg.sv
// Shared definitions for the multi-channel UART CSR block: register offsets,
// field positions, access FSM states and the CTRL field layout.
package apb_uart_csr_pkg;

  localparam logic [4:0] OFF_DIV    = 5'h00;
  localparam logic [4:0] OFF_CTRL   = 5'h04;
  localparam logic [4:0] OFF_STATUS = 5'h08;
  localparam logic [4:0] OFF_IRQEN  = 5'h0C;
  localparam logic [4:0] OFF_ERRCNT = 5'h10;
  localparam int unsigned CH_STRIDE = 32'h20;

  localparam int CTRL_PAR_LSB = 0;
  localparam int CTRL_STOP    = 3;
  localparam int CTRL_LOOP    = 4;

  localparam int ST_RX   = 0;
  localparam int ST_DROP = 1;
  localparam int ST_STOP = 2;

  typedef enum logic {IDLE, ACCESS} apb_st_t;

  // Packing order mirrors the CTRL register image: loopback[4], stop[3], parity[2:0]
  typedef struct packed {
    logic       loopback;
    logic       stop;
    logic [2:0] parity;
  } ctrl_t;

  // Next value of an 8-bit error counter: a clear restarts from zero, and an
  // increment in the same cycle still counts.
  function automatic logic [7:0] cnt_next(input logic [7:0] v, input logic clr,
                                          input logic inc);
    logic [7:0] base;
    base = clr ? 8'h00 : v;
    return (inc && base != 8'hFF) ? base + 8'h01 : base;
  endfunction

endpackage

// File: rtl/apb_uart_csr_mc_if.sv
// APB slave bus bundle for apb_uart_csr_mc, with master and slave views.
interface apb_uart_csr_mc_if #(
  parameter int ADDR_W = 12
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic              pready;
  logic [31:0]       prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_uart_csr_chan.sv
// Register set of one UART channel: divider, frame control, sticky status,
// interrupt enables and, when UART_CSR_ERRCNT_EN is defined, error counters.
module apb_uart_csr_chan
  import apb_uart_csr_pkg::*;
#(
  parameter int DIV_W   = 16,
  parameter int DIV_RST = 868
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [4:0]       off,
  input  logic [31:0]      wdata,
  input  logic             err_rx,
  input  logic             err_dropped,
  input  logic             err_stop,
  output logic [DIV_W-1:0] div,
  output ctrl_t            ctrl,
  output logic             irq,
  output logic [31:0]      rdata
);

  logic [2:0] status;
  logic [2:0] irq_en;
  logic [2:0] pulses;
  logic [2:0] w1c;

  assign pulses[ST_RX]   = err_rx;
  assign pulses[ST_DROP] = err_dropped;
  assign pulses[ST_STOP] = err_stop;
  assign w1c = (wr_en && off == OFF_STATUS) ? wdata[2:0] : 3'b000;

  // A new error pulse wins over a write-1-to-clear in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      div    <= DIV_W'(DIV_RST);
      ctrl   <= '0;
      irq_en <= '0;
      status <= '0;
    end else begin
      if (wr_en && off == OFF_DIV) div <= wdata[DIV_W-1:0];
      if (wr_en && off == OFF_CTRL) begin
        ctrl.parity   <= wdata[CTRL_PAR_LSB +: 3];
        ctrl.stop     <= wdata[CTRL_STOP];
        ctrl.loopback <= wdata[CTRL_LOOP];
      end
      if (wr_en && off == OFF_IRQEN) irq_en <= wdata[2:0];
      status <= (status & ~w1c) | pulses;
    end
  end

  assign irq = |(status & irq_en);

`ifdef UART_CSR_ERRCNT_EN
  logic [7:0] cnt_rx;
  logic [7:0] cnt_drop;
  logic [7:0] cnt_stop;
  logic       cnt_clr;

  assign cnt_clr = wr_en && (off == OFF_ERRCNT);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_rx   <= '0;
      cnt_drop <= '0;
      cnt_stop <= '0;
    end else begin
      cnt_rx   <= cnt_next(cnt_rx, cnt_clr, err_rx);
      cnt_drop <= cnt_next(cnt_drop, cnt_clr, err_dropped);
      cnt_stop <= cnt_next(cnt_stop, cnt_clr, err_stop);
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (off)
      OFF_DIV:    rdata[DIV_W-1:0] = div;
      OFF_CTRL: begin
        rdata[CTRL_PAR_LSB +: 3] = ctrl.parity;
        rdata[CTRL_STOP]         = ctrl.stop;
        rdata[CTRL_LOOP]         = ctrl.loopback;
      end
      OFF_STATUS: rdata[2:0] = status;
      OFF_IRQEN:  rdata[2:0] = irq_en;
`ifdef UART_CSR_ERRCNT_EN
      OFF_ERRCNT: rdata[23:0] = {cnt_stop, cnt_drop, cnt_rx};
`endif
      default:    rdata = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^wdata;

endmodule

// File: rtl/apb_uart_csr_mc.sv
// APB CSR file for NCH UART channels: access FSM with wait states, address
// decode with pslverr, read mux. Optional error counters: UART_CSR_ERRCNT_EN.
module apb_uart_csr_mc
  import apb_uart_csr_pkg::*;
#(
  parameter int NCH         = 2,
  parameter int ADDR_W      = 12,
  parameter int DIV_W       = 16,
  parameter int DIV_RST     = 868,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  apb_uart_csr_mc_if.slave     apb,
  input  logic [NCH-1:0]       err_rx,
  input  logic [NCH-1:0]       err_rx_dropped,
  input  logic [NCH-1:0]       err_stop,
  output logic [NCH*DIV_W-1:0] delitel,
  output logic [NCH*3-1:0]     parity_bit_mode,
  output logic [NCH-1:0]       stop_bit_num,
  output logic [NCH-1:0]       loopback,
  output logic [NCH-1:0]       irq,
  output logic                 irq_any
);

  apb_st_t    state;
  logic [3:0] cnt;
  logic       pready;
  logic       addr_err;
  logic       upper_bad;
  logic       ch_bad;
  logic       off_ok;
  logic       we;
  logic [2:0] ch;
  logic [4:0] off;
  logic [31:0] sel_rdata;
  logic [31:0] chan_rdata [NCH];
  ctrl_t       ctrl_q     [NCH];

  // Access phase: count wait states, complete when the count reaches WAIT_STATES
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (apb.psel && apb.penable) state <= ACCESS;
        end
        ACCESS: begin
          if (!apb.psel || pready) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign pready = (state == ACCESS) && (cnt == 4'(WAIT_STATES));

  assign ch  = apb.paddr[7:5];
  assign off = apb.paddr[4:0];

  generate
    if (ADDR_W > 8) begin : g_upper
      assign upper_bad = |apb.paddr[ADDR_W-1:8];
    end else begin : g_no_upper
      assign upper_bad = 1'b0;
    end
  endgenerate

  assign ch_bad = (32'(ch) >= 32'(NCH));

  always_comb begin
    case (off)
      OFF_DIV, OFF_CTRL, OFF_STATUS, OFF_IRQEN: off_ok = 1'b1;
`ifdef UART_CSR_ERRCNT_EN
      OFF_ERRCNT: off_ok = 1'b1;
`endif
      default: off_ok = 1'b0;
    endcase
  end

  assign addr_err = upper_bad | ch_bad | ~off_ok | (|off[1:0]);
  assign we       = apb.psel && apb.penable && pready && apb.pwrite && !addr_err;

  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NCH; i++) begin
      if (ch == 3'(i)) sel_rdata = chan_rdata[i];
    end
  end

  assign apb.pready  = pready;
  assign apb.pslverr = pready && addr_err;
  assign apb.prdata  = (pready && !apb.pwrite && !addr_err) ? sel_rdata : 32'h0;

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_chan
      apb_uart_csr_chan #(
        .DIV_W   (DIV_W),
        .DIV_RST (DIV_RST)
      ) u_chan (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (we && (ch == 3'(i))),
        .off         (off),
        .wdata       (apb.pwdata),
        .err_rx      (err_rx[i]),
        .err_dropped (err_rx_dropped[i]),
        .err_stop    (err_stop[i]),
        .div         (delitel[i*DIV_W +: DIV_W]),
        .ctrl        (ctrl_q[i]),
        .irq         (irq[i]),
        .rdata       (chan_rdata[i])
      );
      assign parity_bit_mode[i*3 +: 3] = ctrl_q[i].parity;
      assign stop_bit_num[i]           = ctrl_q[i].stop;
      assign loopback[i]               = ctrl_q[i].loopback;
    end
  endgenerate

  assign irq_any = |irq;

endmodule

// File: tb/tb_apb_uart_csr_mc.sv
// Self-checking bench for apb_uart_csr_mc against a register-level model;
// covers the UART_CSR_ERRCNT_EN build when that macro is defined.
module tb_apb_uart_csr_mc;

  localparam int NCH     = 2;
  localparam int ADDR_W  = 12;
  localparam int DIV_W   = 16;
  localparam int DIV_RST = 868;
  localparam int WS      = 3;
  localparam int OUTW    = NCH*DIV_W + 3*NCH + 3*NCH + 1;
  localparam logic [31:0] DIV_MASK = (DIV_W == 32) ? 32'hFFFF_FFFF : ((32'd1 << DIV_W) - 32'd1);
`ifdef UART_CSR_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [NCH-1:0]       err_rx, err_rx_dropped, err_stop;
  logic [NCH*DIV_W-1:0] delitel;
  logic [NCH*3-1:0]     parity_bit_mode;
  logic [NCH-1:0]       stop_bit_num, loopback, irq;
  logic                 irq_any;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  apb_uart_csr_mc_if #(.ADDR_W(ADDR_W)) bus ();

  apb_uart_csr_mc #(
    .NCH(NCH), .ADDR_W(ADDR_W), .DIV_W(DIV_W), .DIV_RST(DIV_RST), .WAIT_STATES(WS)
  ) dut (
    .clk(clk), .rst(rst), .apb(bus),
    .err_rx(err_rx), .err_rx_dropped(err_rx_dropped), .err_stop(err_stop),
    .delitel(delitel), .parity_bit_mode(parity_bit_mode),
    .stop_bit_num(stop_bit_num), .loopback(loopback),
    .irq(irq), .irq_any(irq_any)
  );

  // Reference model: plain per-channel register images
  logic [31:0] m_div    [NCH];
  logic [4:0]  m_ctrl   [NCH];
  logic [2:0]  m_status [NCH];
  logic [2:0]  m_irqen  [NCH];
  int          m_cnt    [NCH][3];

  function automatic void m_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c] = DIV_RST; m_ctrl[c] = '0; m_status[c] = '0; m_irqen[c] = '0;
      for (int k = 0; k < 3; k++) m_cnt[c][k] = 0;
    end
  endfunction

  function automatic logic m_addr_err(input logic [ADDR_W-1:0] a);
    int c, o;
    c = int'(a[7:5]);
    o = int'(a[4:0]);
    if ((a >> 8) != 0) return 1'b1;
    if (a[1:0] != 2'b00) return 1'b1;
    if (c >= NCH) return 1'b1;
    if (o == 0 || o == 4 || o == 8 || o == 12) return 1'b0;
    if (CNT_EN && o == 16) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
    int c, o;
    c = int'(a[7:5]);
    o = int'(a[4:0]);
    case (o)
      0:  return m_div[c];
      4:  return {27'b0, m_ctrl[c]};
      8:  return {29'b0, m_status[c]};
      12: return {29'b0, m_irqen[c]};
      16: return 32'((m_cnt[c][2] << 16) | (m_cnt[c][1] << 8) | m_cnt[c][0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void m_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    int c, o;
    if (m_addr_err(a)) return;
    c = int'(a[7:5]);
    o = int'(a[4:0]);
    case (o)
      0:  m_div[c] = d & DIV_MASK;
      4:  m_ctrl[c] = d[4:0];
      8:  m_status[c] = m_status[c] & ~d[2:0];
      12: m_irqen[c] = d[2:0];
      16: for (int k = 0; k < 3; k++) m_cnt[c][k] = 0;
      default: ;
    endcase
  endfunction

  function automatic void m_pulse(input logic [NCH-1:0] rx, input logic [NCH-1:0] drop,
                                  input logic [NCH-1:0] stp);
    for (int c = 0; c < NCH; c++) begin
      m_status[c] = m_status[c] | {stp[c], drop[c], rx[c]};
      if (CNT_EN) begin
        if (rx[c]   && m_cnt[c][0] < 255) m_cnt[c][0]++;
        if (drop[c] && m_cnt[c][1] < 255) m_cnt[c][1]++;
        if (stp[c]  && m_cnt[c][2] < 255) m_cnt[c][2]++;
      end
    end
  endfunction

  function automatic logic [OUTW-1:0] exp_outs();
    logic [NCH*DIV_W-1:0] dl;
    logic [NCH*3-1:0]     par;
    logic [NCH-1:0]       st, lb, iq;
    for (int c = 0; c < NCH; c++) begin
      dl[c*DIV_W +: DIV_W] = m_div[c][DIV_W-1:0];
      par[c*3 +: 3] = m_ctrl[c][2:0];
      st[c] = m_ctrl[c][3];
      lb[c] = m_ctrl[c][4];
      iq[c] = |(m_status[c] & m_irqen[c]);
    end
    return {dl, par, st, lb, iq, |iq};
  endfunction

  function automatic logic [OUTW-1:0] act_outs();
    return {delitel, parity_bit_mode, stop_bit_num, loopback, irq, irq_any};
  endfunction

  // One APB transfer starting in the current cycle; error pulses are driven in
  // the completing cycle. lat = cycles from first penable cycle to pready, 0 on timeout.
  task automatic apb_xfer(input logic wr, input logic [ADDR_W-1:0] a, input logic [31:0] d,
                          input logic [NCH-1:0] p_rx, input logic [NCH-1:0] p_drop,
                          input logic [NCH-1:0] p_stop,
                          output logic [31:0] rd, output logic er, output int lat);
    int n;
    bit got;
    n = 0; got = 0; rd = 'x; er = 1'bx; lat = 0;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    while (!got && n < 32) begin
      @(negedge clk);
      n++;
      if (bus.pready === 1'b1) begin
        got = 1; rd = bus.prdata; er = bus.pslverr; lat = n;
        err_rx = p_rx; err_rx_dropped = p_drop; err_stop = p_stop;
      end
      @(posedge clk); #1;
    end
    err_rx = '0; err_rx_dropped = '0; err_stop = '0;
    bus.psel = 1'b0; bus.penable = 1'b0;
    if (got) begin
      if (wr) m_write(a, d);
      m_pulse(p_rx, p_drop, p_stop);
    end
  endtask

  task automatic pulse(input logic [NCH-1:0] rx, input logic [NCH-1:0] drop,
                       input logic [NCH-1:0] stp);
    err_rx = rx; err_rx_dropped = drop; err_stop = stp;
    @(posedge clk); #1;
    err_rx = '0; err_rx_dropped = '0; err_stop = '0;
    m_pulse(rx, drop, stp);
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic er; int lat;
    logic [4:0] offs [5] = '{5'h00, 5'h04, 5'h08, 5'h0C, 5'h10};
    bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.paddr = '0; bus.pwdata = '0;
    err_rx = '0; err_rx_dropped = '0; err_stop = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    checks++;
    if ({bus.pready, bus.pslverr, bus.prdata} !== 34'h0) begin
      failures++; $display("[TB] FAIL reset_bus: got %h expected 0", {bus.pready, bus.pslverr, bus.prdata});
    end
    checks++;
    if (act_outs() !== exp_outs()) begin
      failures++; $display("[TB] FAIL reset_outs: got %h expected %h", act_outs(), exp_outs());
    end
    for (int k = 0; k < 5; k++) begin
      if (k == 4 && !CNT_EN) break;
      apb_xfer(1'b0, {4'h0, 3'd1, offs[k]}, 32'h0, '0, '0, '0, rd, er, lat);
      checks++;
      if (lat != 2 + WS || er !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_read_resp off=%h: lat=%0d err=%b expected lat=%0d err=0", offs[k], lat, er, 2 + WS);
      end
      checks++;
      if (rd !== ((k == 0) ? 32'd868 : 32'd0)) begin
        failures++; $display("[TB] FAIL reset_read_val off=%h: got %h expected %h", offs[k], rd, (k == 0) ? 32'd868 : 32'd0);
      end
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(1'b1, 12'h024, 32'h1B, '0, '0, '0, rd, er, lat);
    checks++;
    if (lat != 5 || er !== 1'b0 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL ws_write: lat=%0d err=%b rd=%h expected lat=5 err=0 rd=0", lat, er, rd);
    end
    checks++;
    if ({parity_bit_mode, stop_bit_num, loopback} !== {6'b011_000, 2'b10, 2'b10}) begin
      failures++; $display("[TB] FAIL ws_ctrl_outs: got %b expected %b", {parity_bit_mode, stop_bit_num, loopback}, {6'b011_000, 2'b10, 2'b10});
    end
    checks++;
    if (act_outs() !== exp_outs()) begin
      failures++; $display("[TB] FAIL ws_outs: got %h expected %h", act_outs(), exp_outs());
    end
    apb_xfer(1'b0, 12'h024, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h1B || er !== 1'b0 || lat != 5) begin
      failures++; $display("[TB] FAIL ws_readback: rd=%h err=%b lat=%0d expected 1b/0/5", rd, er, lat);
    end
  endtask

  task automatic test_irq();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(1'b1, 12'h00C, 32'h4, '0, '0, '0, rd, er, lat);
    pulse(2'b00, 2'b00, 2'b01);
    checks++;
    if ({irq, irq_any} !== 3'b011) begin
      failures++; $display("[TB] FAIL irq_set: got %b expected 011", {irq, irq_any});
    end
    apb_xfer(1'b0, 12'h008, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h4 || er !== 1'b0) begin
      failures++; $display("[TB] FAIL irq_status: got %h err=%b expected 4", rd, er);
    end
    pulse(2'b01, 2'b00, 2'b00);
    checks++;
    if (act_outs() !== exp_outs()) begin
      failures++; $display("[TB] FAIL irq_masked_outs: got %h expected %h", act_outs(), exp_outs());
    end
    apb_xfer(1'b1, 12'h008, 32'h4, '0, '0, '0, rd, er, lat);
    checks++;
    if ({irq, irq_any} !== 3'b000) begin
      failures++; $display("[TB] FAIL irq_clear: got %b expected 000", {irq, irq_any});
    end
    apb_xfer(1'b0, 12'h008, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("[TB] FAIL irq_status_after_w1c: got %h expected 1", rd);
    end
  endtask

  task automatic test_w1c_race();
    logic [31:0] rd; logic er; int lat;
    pulse(2'b10, 2'b00, 2'b00);
    apb_xfer(1'b1, 12'h028, 32'h1, 2'b10, 2'b00, 2'b00, rd, er, lat);
    apb_xfer(1'b0, 12'h028, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("[TB] FAIL w1c_race: got %h expected 1", rd);
    end
    apb_xfer(1'b1, 12'h028, 32'h1, '0, '0, '0, rd, er, lat);
    apb_xfer(1'b0, 12'h028, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("[TB] FAIL w1c_plain: got %h expected 0", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat;
    logic [ADDR_W-1:0] bad [6] = '{12'h014, 12'h041, 12'h040, 12'h100, 12'h03C, 12'h006};
    for (int k = 0; k < 6; k++) begin
      apb_xfer(1'b1, bad[k], $urandom, '0, '0, '0, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0 || lat != 2 + WS) begin
        failures++; $display("[TB] FAIL err_write a=%h: err=%b rd=%h lat=%0d expected 1/0/%0d", bad[k], er, rd, lat, 2 + WS);
      end
      apb_xfer(1'b0, bad[k], 32'h0, '0, '0, '0, rd, er, lat);
      checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin
        failures++; $display("[TB] FAIL err_read a=%h: err=%b rd=%h expected 1/0", bad[k], er, rd);
      end
    end
    checks++;
    if (act_outs() !== exp_outs()) begin
      failures++; $display("[TB] FAIL err_no_change: got %h expected %h", act_outs(), exp_outs());
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int lat;
    logic [ADDR_W-1:0] a;
    for (int k = 0; k < 8; k++) begin
      a = {4'h0, 3'($urandom_range(0, NCH-1)), 5'(4 * $urandom_range(0, 3))};
      apb_xfer(1'b1, a, $urandom, '0, '0, '0, rd, er, lat);
      checks++;
      if (lat != 2 + WS || er !== 1'b0) begin
        failures++; $display("[TB] FAIL b2b_write a=%h: lat=%0d err=%b", a, lat, er);
      end
    end
    for (int c = 0; c < NCH; c++) begin
      for (int o = 0; o < 16; o += 4) begin
        a = {4'h0, 3'(c), 5'(o)};
        apb_xfer(1'b0, a, 32'h0, '0, '0, '0, rd, er, lat);
        checks++;
        if (rd !== m_read(a) || lat != 2 + WS) begin
          failures++; $display("[TB] FAIL b2b_read a=%h: got %h lat=%0d expected %h", a, rd, lat, m_read(a));
        end
      end
    end
  endtask

`ifdef UART_CSR_ERRCNT_EN
  task automatic test_errcnt();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(1'b1, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    for (int k = 0; k < 300; k++) pulse(2'b00, 2'b01, 2'b00);
    apb_xfer(1'b0, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h0000_FF00 || er !== 1'b0) begin
      failures++; $display("[TB] FAIL errcnt_sat: got %h err=%b expected 0000ff00", rd, er);
    end
    apb_xfer(1'b1, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    apb_xfer(1'b0, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h0) begin
      failures++; $display("[TB] FAIL errcnt_clear: got %h expected 0", rd);
    end
    apb_xfer(1'b1, 12'h010, 32'h0, 2'b01, 2'b00, 2'b00, rd, er, lat);
    apb_xfer(1'b0, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'h1) begin
      failures++; $display("[TB] FAIL errcnt_clear_inc: got %h expected 1", rd);
    end
  endtask
`else
  task automatic test_errcnt();
    logic [31:0] rd; logic er; int lat;
    apb_xfer(1'b0, 12'h010, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      failures++; $display("[TB] FAIL errcnt_absent: err=%b rd=%h expected 1/0", er, rd);
    end
  endtask
`endif

  task automatic test_random();
    logic [31:0] rd, d, exp_rd; logic er, exp_er, wr; int lat;
    logic [ADDR_W-1:0] a;
    logic [NCH-1:0] prx, pdr, pst;
    int offs [7] = '{0, 4, 8, 12, 16, 20, 28};
    for (int it = 0; it < 300; it++) begin
      a = ADDR_W'($urandom_range(0, NCH) * 32 + offs[$urandom_range(0, 6)]);
      if ($urandom_range(0, 9) == 0) a = a + ADDR_W'($urandom_range(1, 3));
      if ($urandom_range(0, 19) == 0) a = a | 12'h100;
      wr = 1'($urandom_range(0, 1));
      d = $urandom;
      prx = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      pdr = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      pst = ($urandom_range(0, 3) == 0) ? NCH'($urandom) : '0;
      exp_er = m_addr_err(a);
      exp_rd = (wr || exp_er) ? 32'h0 : m_read(a);
      apb_xfer(wr, a, d, prx, pdr, pst, rd, er, lat);
      checks++;
      if (rd !== exp_rd || er !== exp_er || lat != 2 + WS) begin
        failures++; $display("[TB] FAIL rand_xfer it=%0d a=%h wr=%b: rd=%h err=%b lat=%0d expected rd=%h err=%b", it, a, wr, rd, er, lat, exp_rd, exp_er);
      end
      checks++;
      if (act_outs() !== exp_outs()) begin
        failures++; $display("[TB] FAIL rand_outs it=%0d: got %h expected %h", it, act_outs(), exp_outs());
      end
      if ($urandom_range(0, 4) == 0) pulse(NCH'($urandom), NCH'($urandom), NCH'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1; bus.paddr = 12'h000; bus.pwdata = 32'h1234;
    @(posedge clk); #1 bus.penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (bus.pready !== 1'b0) begin
        failures++; $display("[TB] FAIL reset_mid_pready: got %b expected 0", bus.pready);
      end
      @(posedge clk); #1;
    end
    bus.psel = 1'b0; bus.penable = 1'b0; rst = 1'b0;
    m_reset();
    checks++;
    if (act_outs() !== exp_outs()) begin
      failures++; $display("[TB] FAIL reset_mid_outs: got %h expected %h", act_outs(), exp_outs());
    end
    apb_xfer(1'b0, 12'h000, 32'h0, '0, '0, '0, rd, er, lat);
    checks++;
    if (rd !== 32'd868 || lat != 2 + WS) begin
      failures++; $display("[TB] FAIL reset_mid_read: rd=%h lat=%0d expected 364/%0d", rd, lat, 2 + WS);
    end
  endtask

  initial begin
    test_reset();
    test_wait_states();
    test_irq();
    test_w1c_race();
    test_errors();
    test_back_to_back();
    test_errcnt();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
